// File: rtl/note_sequencer.sv
// note_sequencer: walks notes_ROM in address order, prefetches lines into a
// small show-ahead FIFO and hands one line per handshake to the renderer.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start, outputs quiet
// S_FILL  | prefetching, note_valid held low until the buffer is primed
// S_RUN   | prefetching as credits allow, serving pops
// S_DRAIN | last address issued (stop mode), serving remaining lines
// S_DONE  | song finished, song_done high, waiting for start to replay
module note_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int SONG_LEN   = 256,
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int LOOP       = 1
) (
  input  logic              vgaclk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [LANES-1:0]  rom_data,
  input  logic              note_ready,
  output logic              note_valid,
  output logic [LANES-1:0]  note_line,
  output logic              song_done,
  output logic              underflow,
  output logic [15:0]       lines_issued
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W:0]    DEPTH_C   = (CNT_W + 1)'(FIFO_DEPTH);
  localparam bit                STOP_AT_END = (LOOP == 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] next_addr;
  logic              issue_done;
  // pipe[0]: read issued on the last edge; pipe[1]: its data is on rom_data now
  logic [1:0]        pipe;
  logic [LANES-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupancy;
  logic              issue, push, pop, restart, serving;

  // Credit check counts in-flight reads so a push can never find the FIFO full
  assign occupancy = (CNT_W + 1)'(count) + (CNT_W + 1)'(pipe[0]) + (CNT_W + 1)'(pipe[1]);
  assign issue     = (state == S_FILL || state == S_RUN) && !issue_done && (occupancy < DEPTH_C);
  assign push      = pipe[1];
  assign serving   = (state == S_RUN) || (state == S_DRAIN);
  assign note_valid = serving && (count != '0);
  assign note_line = mem[rd_ptr];
  assign pop       = note_valid && note_ready;
  assign song_done = (state == S_DONE);
  assign restart   = start && (state == S_IDLE || state == S_DONE);

  // State register
  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FILL;
      S_FILL:  if (count == FULL_CNT || (issue_done && pipe == 2'b00)) state_nxt = S_RUN;
      S_RUN:   if (issue_done) state_nxt = S_DRAIN;
      S_DRAIN: if (count == '0 && pipe == 2'b00) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_FILL;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ROM address generation and read-latency pipe
  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr   <= '0;
      next_addr  <= '0;
      issue_done <= 1'b0;
      pipe       <= 2'b00;
    end else begin
      pipe <= {pipe[0], issue};
      if (restart) begin
        rom_addr   <= '0;
        next_addr  <= '0;
        issue_done <= 1'b0;
      end else if (issue) begin
        rom_addr <= next_addr;
        if (next_addr == LAST_ADDR) begin
          next_addr <= '0;
          if (STOP_AT_END) issue_done <= 1'b1;
        end else begin
          next_addr <= next_addr + ADDR_W'(1);
        end
      end
    end
  end

  // Show-ahead FIFO storage and occupancy
  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= rom_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Delivered-line counter and sticky underflow flag
  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      lines_issued <= '0;
      underflow    <= 1'b0;
    end else begin
      if (pop) lines_issued <= lines_issued + 16'd1;
      if (serving && note_ready && !note_valid) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed checks of fill, streaming, stop/loop modes,
// underflow and asynchronous reset on three differently configured instances.
module tb_note_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;

  // main instance: defaults (SONG_LEN=256, LOOP=1)
  logic [7:0]  m_rom_addr;
  logic [3:0]  m_rom_data = '0;
  logic        m_ready = 1'b0;
  logic        m_valid, m_done, m_uflow;
  logic [3:0]  m_line;
  logic [15:0] m_issued;

  // stop instance: SONG_LEN=6, LOOP=0
  logic [7:0]  s_rom_addr;
  logic [3:0]  s_rom_data = '0;
  logic        s_ready = 1'b0;
  logic        s_valid, s_done, s_uflow;
  logic [3:0]  s_line;
  logic [15:0] s_issued;

  // loop instance: SONG_LEN=3, LOOP=1
  logic [7:0]  l_rom_addr;
  logic [3:0]  l_rom_data = '0;
  logic        l_ready = 1'b0;
  logic        l_valid, l_done, l_uflow;
  logic [3:0]  l_line;
  logic [15:0] l_issued;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  note_sequencer u_main (
    .vgaclk(clk), .rst_n(rst_n), .start(start), .rom_addr(m_rom_addr), .rom_data(m_rom_data),
    .note_ready(m_ready), .note_valid(m_valid), .note_line(m_line), .song_done(m_done),
    .underflow(m_uflow), .lines_issued(m_issued));

  note_sequencer #(.SONG_LEN(6), .LOOP(0)) u_stop (
    .vgaclk(clk), .rst_n(rst_n), .start(start), .rom_addr(s_rom_addr), .rom_data(s_rom_data),
    .note_ready(s_ready), .note_valid(s_valid), .note_line(s_line), .song_done(s_done),
    .underflow(s_uflow), .lines_issued(s_issued));

  note_sequencer #(.SONG_LEN(3), .LOOP(1)) u_loop (
    .vgaclk(clk), .rst_n(rst_n), .start(start), .rom_addr(l_rom_addr), .rom_data(l_rom_data),
    .note_ready(l_ready), .note_valid(l_valid), .note_line(l_line), .song_done(l_done),
    .underflow(l_uflow), .lines_issued(l_issued));

  // Registered ROMs: line n holds n[3:0]
  always @(posedge clk) begin
    m_rom_data <= m_rom_addr[3:0];
    s_rom_data <= s_rom_addr[3:0];
    l_rom_data <= l_rom_addr[3:0];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    start = 1'b0;
    m_ready = 1'b0;
    s_ready = 1'b0;
    l_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int fill_addr [10] = '{0, 0, 1, 2, 3, 3, 3, 3, 3, 3};
  int fill_vld  [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1};

  initial begin
    int exp_k;
    int budget;

    // reset state
    do_reset();
    chk("rst_addr", m_rom_addr, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_line", m_line, 0);
    chk("rst_done", m_done, 0);
    chk("rst_uflow", m_uflow, 0);
    chk("rst_issued", m_issued, 0);

    // fill with no pops: four reads, then hold; valid only once full
    @(negedge clk);
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("fill_addr%0d", i), m_rom_addr, fill_addr[i]);
      chk($sformatf("fill_valid%0d", i), m_valid, fill_vld[i]);
    end
    chk("fill_line", m_line, 0);
    chk("fill_issued", m_issued, 0);

    // streaming: continuous ready, no gaps, increasing line values
    m_ready = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      chk($sformatf("strm_valid%0d", i), m_valid, 1);
      chk($sformatf("strm_line%0d", i), m_line, i % 16);
      chk($sformatf("strm_issued%0d", i), m_issued, i);
    end
    m_ready = 1'b0;
    chk("strm_uflow", m_uflow, 0);

    // asynchronous reset mid-run with partially refilled buffer
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", m_valid, 0);
    chk("arst_line", m_line, 0);
    chk("arst_addr", m_rom_addr, 0);
    chk("arst_issued", m_issued, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_valid", m_valid, 0);
    chk("post_rst_addr", m_rom_addr, 0);

    // stop mode: six lines, one pop per ten cycles
    do_reset();
    pulse_start();
    for (int k = 0; k < 6; k++) begin
      budget = 0;
      while (!s_valid && budget < 50) begin
        @(negedge clk);
        budget++;
      end
      chk($sformatf("stop_valid%0d", k), s_valid, 1);
      chk($sformatf("stop_line%0d", k), s_line, k);
      s_ready = 1'b1;
      @(negedge clk);
      s_ready = 1'b0;
      repeat (9) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("stop_end_valid", s_valid, 0);
    chk("stop_end_done", s_done, 1);
    chk("stop_end_issued", s_issued, 6);
    chk("stop_end_uflow", s_uflow, 0);

    // replay with ready held high; the empty drain cycle flags underflow
    pulse_start();
    chk("replay_done_clr", s_done, 0);
    s_ready = 1'b1;
    exp_k = 0;
    budget = 0;
    while (exp_k < 6 && budget < 100) begin
      @(negedge clk);
      budget++;
      if (s_valid) begin
        chk($sformatf("replay_line%0d", exp_k), s_line, exp_k);
        exp_k++;
      end
    end
    chk("replay_count", exp_k, 6);
    chk("replay_uflow_pre", s_uflow, 0);
    repeat (5) @(negedge clk);
    chk("replay_uflow", s_uflow, 1);
    chk("replay_done", s_done, 1);
    chk("replay_valid", s_valid, 0);
    chk("replay_issued", s_issued, 12);
    s_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("uflow_sticky", s_uflow, 1);

    // loop mode: 0,1,2 repeating, never done
    do_reset();
    pulse_start();
    budget = 0;
    while (!l_valid && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    chk("loop_first_valid", l_valid, 1);
    l_ready = 1'b1;
    exp_k = 0;
    budget = 0;
    while (exp_k < 12 && budget < 100) begin
      if (l_valid) begin
        chk($sformatf("loop_line%0d", exp_k), l_line, exp_k % 3);
        exp_k++;
      end
      @(negedge clk);
      budget++;
    end
    l_ready = 1'b0;
    chk("loop_count", exp_k, 12);
    chk("loop_issued", l_issued, 12);
    chk("loop_done", l_done, 0);
    chk("loop_uflow", l_uflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Upstream feeder for the scrolling-note VGA renderer.
- Walks the song in notes_ROM in address order and prefetches note lines into a small show-ahead FIFO.
- Hands one 4-lane note line to the renderer each time a beat row wraps, using a valid/ready handshake.
- Handles song end (loop or stop) and flags renderer underflow.

Parameters:
- ADDR_W, 8: notes_ROM address width.
- SONG_LEN, 256: number of ROM lines in the song (1..2^ADDR_W).
- LANES, 4: note lanes per line.
- FIFO_DEPTH, 4: prefetch buffer entries (power of two, >=2).
- LOOP, 1: 1 = wrap to address 0 after the last line; 0 = stop after the last line.

Ports:
- vgaclk  in  1  pixel clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins playback from address 0.
- rom_addr  out  ADDR_W  address to notes_ROM.
- rom_data  in  LANES  notes_ROM q output; registered ROM.
- note_ready  in  1  renderer pops the head line this cycle.
- note_valid  out  1  head line available.
- note_line  out  LANES  head line; bit i = note present in lane i.
- song_done  out  1  level; playback finished (LOOP=0 only).
- underflow  out  1  sticky; renderer popped while empty.
- lines_issued  out  16  count of lines handed to the renderer.

Behaviour:
- Clocking and reset
  - One clock domain (vgaclk); reset is asynchronous and active-low (rst_n).
  - On rst_n low, all state clears immediately: state=IDLE, rom_addr=0, FIFO empty, in-flight=0, note_valid=0, note_line=0, song_done=0, underflow=0, lines_issued=0.
  - Reset mid-playback discards all buffered and in-flight data; nothing is delivered after reset release.
- ROM timing
  - rom_addr is a register.
  - A read issued on edge k (rom_addr updated) has valid rom_data captured into the FIFO on edge k+2.
  - Fixed 2-cycle read latency, tracked by a 2-stage in-flight pipe.
- Issue rule
  - Issue a read when state is FILL or RUN, addresses remain, and (fifo_count + in_flight) < FIFO_DEPTH.
  - This credit check guarantees the FIFO never overflows.
  - At most one read is issued per cycle.
- FSM
  - IDLE: outputs quiet. start -> FILL.
  - FILL: issue reads. Go to RUN when fifo_count == FIFO_DEPTH, or when all SONG_LEN lines are issued and in-flight == 0.
  - RUN: issue reads as credits allow; serve pops. When LOOP=0 and the last address has been issued -> DRAIN.
  - DRAIN: no issues; serve pops. FIFO empty and in-flight == 0 -> DONE.
  - DONE: song_done=1 and note_valid=0. start -> clear song_done, rom_addr=0, go to FILL.
  - start in FILL, RUN or DRAIN is ignored.
- Addressing
  - After issuing address SONG_LEN-1: LOOP=1 -> next address is 0 and playback continues indefinitely; LOOP=0 -> no further issues.
- FIFO
  - Show-ahead: note_line = head entry, note_valid = (fifo_count > 0) in FILL, RUN and DRAIN.
  - note_valid is forced 0 in FILL until the FIFO is first full, so the renderer never starts on a partial buffer.
  - Pop occurs when note_valid && note_ready.
  - Push and pop on the same edge: count unchanged, data order preserved.
  - A line of all zeros (rest) is a valid line and is delivered normally.
- Counters and flags
  - lines_issued increments by 1 on each pop and wraps at 2^16.
  - underflow sets on note_ready && !note_valid while in RUN or DRAIN, and holds until reset.
  - note_ready in IDLE, FILL or DONE has no effect.

Test Plan:
- Fill: reset, ROM line n = n[3:0], start pulse, note_ready=0 -> rom_addr issues 0,1,2,3 on consecutive cycles and then holds. note_valid rises once 4 entries are captured, note_line=4'h0. No 5th read is issued.
- Streaming: note_ready=1 continuously after valid -> note_line sequence 0,1,2,...,15,0,... with no gaps once steady. lines_issued increments each cycle; FIFO never exceeds 4 entries.
- Stop mode: LOOP=0, SONG_LEN=6, one pop per 10 cycles -> exactly 6 lines delivered (values 0..5). Then note_valid=0 and song_done=1. A later start replays from line 0.
- Loop mode: LOOP=1, SONG_LEN=3 -> delivered lines 0,1,2,0,1,2,... and song_done stays 0.
- Underflow: note_ready held high while the ROM is throttled to the 2-cycle latency with FIFO empty in RUN -> underflow sets and stays 1. Delivered data order is still correct.
- Reset mid-run: rst_n low for 1 cycle asynchronously with 3 entries buffered -> outputs are zero immediately. After release with no start, note_valid stays 0 and rom_addr=0.
